// File: rtl/cv32e40p_fetch_unit_mo.sv
// Instruction-fetch front end: issues OBI requests with bounded outstanding
// transactions, buffers returned words in a small FIFO, discards responses
// that belong to a fetch stream abandoned by a branch, and stops fetching
// after a bus error until the next branch.
//
// state  | meaning
// S_IDLE | normal issue; instr_addr_o follows next_addr
// S_HOLD | branch arrived while a request was waiting for grant; the old
//        | request is kept stable until granted, target parked in shadow
module cv32e40p_fetch_unit_mo #(
    parameter int DEPTH           = 4,
    parameter int MAX_OUTSTANDING = 2,
    parameter bit PULP_OBI        = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_i,
    input  logic        branch_i,
    input  logic [31:0] branch_addr_i,
    output logic        fetch_valid_o,
    input  logic        fetch_ready_i,
    output logic [31:0] fetch_rdata_o,
    output logic [31:0] fetch_addr_o,
    output logic        fetch_err_o,
    output logic        instr_req_o,
    output logic [31:0] instr_addr_o,
    input  logic        instr_gnt_i,
    input  logic        instr_rvalid_i,
    input  logic [31:0] instr_rdata_i,
    input  logic        instr_err_i,
    output logic        busy_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] LP_MAX_OUT = MAX_OUTSTANDING[CW-1:0];
    localparam logic [CW-1:0] LP_FULL    = DEPTH[CW-1:0];
    localparam logic [CW:0]   LP_DEPTH_X = DEPTH[CW:0];

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [31:0]   r_next_addr;
    logic [31:0]   r_shadow_addr;
    logic [31:0]   r_rsp_addr;
    logic [CW-1:0] r_outstanding;
    logic [CW-1:0] r_discard;
    logic [CW-1:0] r_count;
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic          r_armed;
    logic          r_err_halt;
    logic [31:0]   r_fifo_data [DEPTH];
    logic [31:0]   r_fifo_addr [DEPTH];
    logic [DEPTH-1:0] r_fifo_err;

    logic [31:0]   w_target;
    logic [31:0]   w_next_addr_nxt;
    logic [31:0]   w_shadow_nxt;
    logic [CW-1:0] w_out_nxt;
    logic [CW-1:0] w_discard_nxt;
    logic [CW:0]   w_inflight;
    logic          w_can_issue;
    logic          w_gnt;
    logic          w_rvalid;
    logic          w_drop;
    logic          w_push;
    logic          w_pop;

    // Low address bits are masked rather than left dangling.
    assign w_target     = {branch_addr_i[31:2], branch_addr_i[1:0] & 2'b00};

    // Slots are reserved at issue time, so every kept response has room.
    assign w_inflight   = {1'b0, r_count} + {1'b0, r_outstanding};
    assign w_can_issue  = r_armed & req_i & ~r_err_halt
                        & (r_outstanding < LP_MAX_OUT) & (w_inflight < LP_DEPTH_X);
    assign instr_req_o  = (r_state == S_HOLD) | w_can_issue;
    assign instr_addr_o = r_next_addr;
    assign w_gnt        = instr_req_o & instr_gnt_i;
    assign w_rvalid     = instr_rvalid_i & (r_outstanding != '0);
    assign w_drop       = w_rvalid & (r_discard != '0);
    assign w_push       = w_rvalid & ~w_drop;
    assign w_pop        = fetch_valid_o & fetch_ready_i;
    assign w_out_nxt    = r_outstanding + CW'(w_gnt) - CW'(w_rvalid);

    assign fetch_valid_o = (r_count != '0);
    assign fetch_rdata_o = r_fifo_data[r_rptr];
    assign fetch_addr_o  = r_fifo_addr[r_rptr];
    assign fetch_err_o   = r_fifo_err[r_rptr];
    assign busy_o        = instr_req_o | (r_outstanding != '0);

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, next fetch address, shadow target and discard count.
    always_comb begin
        w_state_nxt     = r_state;
        w_next_addr_nxt = r_next_addr;
        w_shadow_nxt    = r_shadow_addr;
        w_discard_nxt   = r_discard - CW'(w_drop);
        case (r_state)
            S_IDLE: begin
                if (w_gnt) begin
                    w_next_addr_nxt = r_next_addr + 32'd4;
                end
                if (branch_i) begin
                    w_discard_nxt = w_out_nxt;
                    if ((PULP_OBI == 1'b0) && instr_req_o && !instr_gnt_i) begin
                        w_state_nxt     = S_HOLD;
                        w_shadow_nxt    = w_target;
                        w_next_addr_nxt = r_next_addr;
                    end else begin
                        w_next_addr_nxt = w_target;
                    end
                end
            end
            S_HOLD: begin
                if (branch_i) begin
                    w_discard_nxt = w_out_nxt;
                    w_shadow_nxt  = w_target;
                end
                if (w_gnt) begin
                    w_state_nxt = S_IDLE;
                    if (branch_i) begin
                        w_next_addr_nxt = w_target;
                    end else begin
                        w_next_addr_nxt = r_shadow_addr;
                        // The held request belongs to the abandoned stream.
                        w_discard_nxt   = r_discard - CW'(w_drop) + CW'(1);
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Request/response bookkeeping. Kept responses are contiguous from the
    // last branch target, so one running address replaces a per-request queue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_next_addr   <= '0;
            r_shadow_addr <= '0;
            r_rsp_addr    <= '0;
            r_outstanding <= '0;
            r_discard     <= '0;
            r_armed       <= 1'b0;
            r_err_halt    <= 1'b0;
        end else begin
            r_next_addr   <= w_next_addr_nxt;
            r_shadow_addr <= w_shadow_nxt;
            r_outstanding <= w_out_nxt;
            r_discard     <= w_discard_nxt;
            if (branch_i) begin
                r_armed    <= 1'b1;
                r_err_halt <= 1'b0;
                r_rsp_addr <= w_target;
            end else begin
                if (w_push) begin
                    r_rsp_addr <= r_rsp_addr + 32'd4;
                end
                if (w_push && instr_err_i) begin
                    r_err_halt <= 1'b1;
                end
            end
        end
    end

    // FIFO pointers and occupancy; a branch empties the FIFO outright.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (branch_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // FIFO storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_fifo_data[i] <= '0;
                r_fifo_addr[i] <= '0;
            end
            r_fifo_err <= '0;
        end else if (w_push && !branch_i) begin
            r_fifo_data[r_wptr] <= instr_rdata_i;
            r_fifo_addr[r_wptr] <= r_rsp_addr;
            r_fifo_err[r_wptr]  <= instr_err_i;
        end
    end

`ifndef SYNTHESIS
    // Overflow cannot happen by construction; stray responses are a bus fault.
    always @(posedge clk) begin
        if (rst_n) begin
            assert (!(w_push && !w_pop && !branch_i && (r_count == LP_FULL)))
                else $error("fetch FIFO overflow");
            assert (!(instr_rvalid_i && (r_outstanding == '0)))
                else $error("rvalid with no outstanding request");
        end
    end
`endif

endmodule

// File: tb/tb_cv32e40p_fetch_unit_mo.sv
// Directed bench for the fetch unit: an OBI memory model answers one cycle
// after grant (responses can be held back), popped words and granted
// addresses are logged, and expectations are hand-computed.
module tb_cv32e40p_fetch_unit_mo;
    logic        clk;
    logic        rst_n;
    logic        req_i;
    logic        branch_i;
    logic [31:0] branch_addr_i;
    logic        fetch_valid_o;
    logic        fetch_ready_i;
    logic [31:0] fetch_rdata_o;
    logic [31:0] fetch_addr_o;
    logic        fetch_err_o;
    logic        instr_req_o;
    logic [31:0] instr_addr_o;
    logic        instr_gnt_i;
    logic        instr_rvalid_i;
    logic [31:0] instr_rdata_i;
    logic        instr_err_i;
    logic        busy_o;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] got_addr[$];
    logic [31:0] got_data[$];
    logic [31:0] got_err[$];
    logic [31:0] glog[$];
    logic [31:0] sq[$];
    logic        rsp_en;
    logic [31:0] err_addr;

    cv32e40p_fetch_unit_mo #(
        .DEPTH(4),
        .MAX_OUTSTANDING(2),
        .PULP_OBI(1'b0)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_i(req_i),
        .branch_i(branch_i),
        .branch_addr_i(branch_addr_i),
        .fetch_valid_o(fetch_valid_o),
        .fetch_ready_i(fetch_ready_i),
        .fetch_rdata_o(fetch_rdata_o),
        .fetch_addr_o(fetch_addr_o),
        .fetch_err_o(fetch_err_o),
        .instr_req_o(instr_req_o),
        .instr_addr_o(instr_addr_o),
        .instr_gnt_i(instr_gnt_i),
        .instr_rvalid_i(instr_rvalid_i),
        .instr_rdata_i(instr_rdata_i),
        .instr_err_i(instr_err_i),
        .busy_o(busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One clock: sample mid-cycle, then advance the memory model after the edge.
    task automatic tick();
        logic        s_gnt;
        logic        s_rv;
        logic [31:0] s_gaddr;
        @(negedge clk);
        if (fetch_valid_o && fetch_ready_i) begin
            got_addr.push_back(fetch_addr_o);
            got_data.push_back(fetch_rdata_o);
            got_err.push_back({31'b0, fetch_err_o});
        end
        s_gnt   = instr_req_o & instr_gnt_i;
        s_gaddr = instr_addr_o;
        s_rv    = instr_rvalid_i;
        if (s_gnt) glog.push_back(s_gaddr);
        @(posedge clk);
        #1;
        if (s_rv && sq.size() > 0) void'(sq.pop_front());
        if (s_gnt) sq.push_back(s_gaddr);
        if (rsp_en && sq.size() > 0) begin
            instr_rvalid_i = 1'b1;
            instr_rdata_i  = mem(sq[0]);
            instr_err_i    = (sq[0] == err_addr);
        end else begin
            instr_rvalid_i = 1'b0;
            instr_rdata_i  = '0;
            instr_err_i    = 1'b0;
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_branch(input logic [31:0] a);
        branch_addr_i = a;
        branch_i      = 1'b1;
        tick();
        branch_i = 1'b0;
        got_addr.delete();
        got_data.delete();
        got_err.delete();
        glog.delete();
    endtask

    initial begin
        rst_n          = 1'b0;
        req_i          = 1'b0;
        branch_i       = 1'b0;
        branch_addr_i  = '0;
        fetch_ready_i  = 1'b0;
        instr_gnt_i    = 1'b0;
        instr_rvalid_i = 1'b0;
        instr_rdata_i  = '0;
        instr_err_i    = 1'b0;
        rsp_en         = 1'b1;
        err_addr       = 32'hFFFF_FFFF;

        // Reset state
        #12;
        check("rst_valid", fetch_valid_o, 0);
        check("rst_req", instr_req_o, 0);
        check("rst_iaddr", instr_addr_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_fdata", fetch_rdata_o, 0);
        check("rst_faddr", fetch_addr_o, 0);
        check("rst_ferr", fetch_err_o, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // No fetching before the first branch
        req_i         = 1'b1;
        instr_gnt_i   = 1'b1;
        fetch_ready_i = 1'b1;
        ticks(2);
        check("no_boot_req", instr_req_o, 0);

        // Test 1: streaming from 0x80, first word two edges after the branch edge
        do_branch(32'h80);
        check("t1_req", instr_req_o, 1);
        check("t1_req_addr", instr_addr_o, 32'h80);
        tick();
        check("t1_valid_early", fetch_valid_o, 0);
        tick();
        check("t1_valid_first", fetch_valid_o, 1);
        check("t1_addr_first", fetch_addr_o, 32'h80);
        ticks(8);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t1_addr%0d", i), got_addr[i], 32'h80 + 32'(4 * i));
        end
        check("t1_data2", got_data[2], mem(32'h88));

        // Test 2: consumer stalled, fetch stops with FIFO full, then resumes
        fetch_ready_i = 1'b0;
        do_branch(32'h1000);
        ticks(10);
        check("t2_nreq", glog.size(), 4);
        check("t2_req_off", instr_req_o, 0);
        check("t2_valid", fetch_valid_o, 1);
        check("t2_head", fetch_addr_o, 32'h1000);
        check("t2_busy", busy_o, 0);
        fetch_ready_i = 1'b1;
        ticks(12);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("t2_addr%0d", i), got_addr[i], 32'h1000 + 32'(4 * i));
        end
        check("t2_data5", got_data[5], mem(32'h1014));

        // Test 3: two outstanding responses dropped by a branch
        req_i = 1'b0;
        ticks(4);
        check("t3_drained", busy_o, 0);
        rsp_en = 1'b0;
        do_branch(32'h100);
        req_i = 1'b1;
        ticks(2);
        check("t3_issued", glog.size(), 2);
        check("t3_req_cap", instr_req_o, 0);
        check("t3_busy", busy_o, 1);
        rsp_en = 1'b1;
        do_branch(32'h200);
        ticks(8);
        check("t3_addr0", got_addr[0], 32'h200);
        check("t3_data0", got_data[0], mem(32'h200));
        check("t3_addr1", got_addr[1], 32'h204);

        // Test 4: branch while a request waits for grant
        req_i = 1'b0;
        ticks(4);
        instr_gnt_i = 1'b0;
        do_branch(32'h40);
        req_i = 1'b1;
        #1;
        check("t4_req", instr_req_o, 1);
        check("t4_addr", instr_addr_o, 32'h40);
        do_branch(32'h300);
        check("t4_hold_req", instr_req_o, 1);
        check("t4_hold_addr_a", instr_addr_o, 32'h40);
        tick();
        check("t4_hold_addr_b", instr_addr_o, 32'h40);
        instr_gnt_i = 1'b1;
        tick();
        check("t4_after_gnt", instr_addr_o, 32'h300);
        ticks(6);
        check("t4_g0", glog[0], 32'h40);
        check("t4_g1", glog[1], 32'h300);
        check("t4_out0", got_addr[0], 32'h300);
        check("t4_data0", got_data[0], mem(32'h300));

        // Test 5: bus error at 0x24 halts fetching until the next branch
        err_addr = 32'h24;
        do_branch(32'h18);
        ticks(10);
        check("t5_nreq", glog.size(), 5);
        check("t5_last_req", glog[4], 32'h28);
        check("t5_req_off", instr_req_o, 0);
        check("t5_err_addr", got_addr[3], 32'h24);
        check("t5_err_flag", got_err[3], 1);
        check("t5_prev_ok", got_err[2], 0);
        check("t5_tail_addr", got_addr[4], 32'h28);
        check("t5_tail_ok", got_err[4], 0);
        err_addr = 32'hFFFF_FFFF;
        do_branch(32'h0);
        ticks(6);
        check("t5_resume_req", glog[0], 32'h0);
        check("t5_resume_addr", got_addr[0], 32'h0);
        check("t5_resume_err", got_err[0], 0);

        // Test 6: branch in the same cycle as pop, rvalid and grant
        branch_addr_i = 32'h500;
        branch_i      = 1'b1;
        #1;
        check("t6_coincide",
              {29'b0, fetch_valid_o & fetch_ready_i, instr_req_o & instr_gnt_i, instr_rvalid_i},
              32'h7);
        tick();
        branch_i = 1'b0;
        got_addr.delete();
        got_data.delete();
        got_err.delete();
        glog.delete();
        check("t6_flushed", fetch_valid_o, 0);
        ticks(6);
        check("t6_addr0", got_addr[0], 32'h500);
        check("t6_data0", got_data[0], mem(32'h500));
        check("t6_addr1", got_addr[1], 32'h504);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
